// File: rtl/waverforms_pkg.sv
// Shared definitions for the waveform multiplier-sharing slice.
//   MUL_W           : datapath width of the shared multiplier (32)
//   MAX_REQ         : widest request vector the priority helper understands
//   mul_arb_state_t : arbiter/sequencer states IDLE -> MUL -> RESP
//   rrFirstSet()    : first set bit of a vector, searched upward from a
//                     rotating start index and wrapping at numReq
package waverforms_pkg;

  localparam int MUL_W   = 32;
  localparam int MAX_REQ = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } mul_arb_state_t;

  // Walks numReq positions starting at 'start'. The running index never
  // exceeds 2*numReq-1, so one conditional subtract replaces a modulo.
  // When no bit is set the start index is returned; callers qualify the
  // result with an OR-reduction of the vector.
  function automatic logic [3:0] rrFirstSet(input logic [MAX_REQ-1:0] vec,
                                            input logic [3:0]         start,
                                            input int                 numReq);
    logic [3:0] pick;
    logic [4:0] sum;
    logic [3:0] idx;
    logic       found;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < numReq) begin
        sum = {1'b0, start} + 5'(i);
        if (sum >= 5'(numReq)) begin
          sum = sum - 5'(numReq);
        end
        idx = sum[3:0];
        if (!found && vec[idx]) begin
          pick  = idx;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/waverforms_mul_32s_32ns_32_1_1.sv
// Combinational multiplier core: signed din0 times unsigned din1, keeping
// the low dout_WIDTH bits of the product (two's-complement wrap).
//   din0 : signed operand
//   din1 : unsigned operand (zero-extended before the signed multiply)
//   dout : low dout_WIDTH bits of the product
module waverforms_mul_32s_32ns_32_1_1 #(
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 32,
  parameter int dout_WIDTH = 32
) (
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout
);

  logic signed [dout_WIDTH-1:0] aExt;
  logic signed [dout_WIDTH-1:0] bExt;

  // The low N bits of a product depend only on the low N bits of each
  // operand, so both operands are brought to the output width first. The
  // extra zero bit on din1 makes it behave as unsigned inside a signed
  // multiply.
  assign aExt = dout_WIDTH'($signed(din0));
  assign bExt = dout_WIDTH'($signed({1'b0, din1}));
  assign dout = aExt * bExt;

endmodule

// File: rtl/waverforms_mul_arbiter.sv
// Round-robin arbiter and sequencer sharing one 32s x 32ns -> 32 multiplier
// among NUM_REQ waveform channels.
//   ap_clk / ap_rst : clock, synchronous active-high reset
//   req_valid       : per-requester operand valid
//   req_ready       : one-hot accept, only in the IDLE grant cycle
//   req_a / req_b   : packed signed A / unsigned B operands, 32 bits each
//   resp_valid      : one-hot result valid, held until accepted
//   resp_ready      : per-requester result accept (only the granted bit counts)
//   resp_data       : low 32 bits of the product
//   busy            : state is not IDLE
//   op_count        : completed operations, wraps modulo 2^32
module waverforms_mul_arbiter
  import waverforms_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*MUL_W-1:0] req_a,
  input  logic [NUM_REQ*MUL_W-1:0] req_b,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic [MUL_W-1:0]         resp_data,
  output logic                     busy,
  output logic [MUL_W-1:0]         op_count
);

  mul_arb_state_t   state_q, state_d;
  logic [ID_W-1:0]  rrPtr_q, rrPtr_d;
  logic [ID_W-1:0]  gntId_q, gntId_d;
  logic [MUL_W-1:0] opA_q, opA_d;
  logic [MUL_W-1:0] opB_q, opB_d;
  logic [MUL_W-1:0] res_q, res_d;
  logic [MUL_W-1:0] opCount_q, opCount_d;
  logic [MUL_W-1:0] mulOut;
  logic [ID_W-1:0]  grantIdx;
  logic             anyValid;
  logic             respAccept;

  waverforms_mul_32s_32ns_32_1_1 #(
    .din0_WIDTH(MUL_W),
    .din1_WIDTH(MUL_W),
    .dout_WIDTH(MUL_W)
  ) uMul (
    .din0(opA_q),
    .din1(opB_q),
    .dout(mulOut)
  );

  // Round-robin pick depends only on req_valid and the rotating pointer,
  // so the grant is visible combinationally in the same cycle.
  always_comb begin
    anyValid   = |req_valid;
    grantIdx   = ID_W'(rrFirstSet(MAX_REQ'(req_valid), 4'(rrPtr_q), NUM_REQ));
    respAccept = resp_ready[gntId_q];
  end

  // Next-state and handshake outputs. Handshakes are suppressed while reset
  // is high because any transfer in that cycle would be discarded anyway.
  always_comb begin
    state_d    = state_q;
    rrPtr_d    = rrPtr_q;
    gntId_d    = gntId_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    res_d      = res_q;
    opCount_d  = opCount_q;
    req_ready  = '0;
    resp_valid = '0;
    case (state_q)
      IDLE: begin
        if (anyValid && !ap_rst) begin
          req_ready[grantIdx] = 1'b1;
          gntId_d = grantIdx;
          opA_d   = req_a[MUL_W*grantIdx +: MUL_W];
          opB_d   = req_b[MUL_W*grantIdx +: MUL_W];
          rrPtr_d = (grantIdx == ID_W'(NUM_REQ-1)) ? '0 : grantIdx + ID_W'(1);
          state_d = MUL;
        end
      end
      MUL: begin
        res_d   = mulOut;
        state_d = RESP;
      end
      RESP: begin
        if (!ap_rst) begin
          resp_valid[gntId_q] = 1'b1;
        end
        if (respAccept) begin
          opCount_d = opCount_q + 32'd1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset wins over any in-flight operation.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q   <= IDLE;
      rrPtr_q   <= '0;
      gntId_q   <= '0;
      opA_q     <= '0;
      opB_q     <= '0;
      res_q     <= '0;
      opCount_q <= '0;
    end else begin
      state_q   <= state_d;
      rrPtr_q   <= rrPtr_d;
      gntId_q   <= gntId_d;
      opA_q     <= opA_d;
      opB_q     <= opB_d;
      res_q     <= res_d;
      opCount_q <= opCount_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign resp_data = res_q;
  assign op_count  = opCount_q;

endmodule

// File: tb/tb_waverforms_mul_arbiter.sv
// Self-checking bench for waverforms_mul_arbiter: directed scenarios plus a
// randomized run, all compared against a transaction-level reference model.
module tb_waverforms_mul_arbiter;

  localparam int N = 4;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [N-1:0]  resp_valid;
  logic [N-1:0]  resp_ready;
  logic [31:0]   resp_data;
  logic          busy;
  logic [31:0]   op_count;

  int checks   = 0;
  int failures = 0;
  int cycleNo  = 0;

  // Reference model: phase 0 = waiting, 1 = computing, 2 = presenting result
  int          mPhase, mPtr, mGnt;
  logic [31:0] mA, mB, mRes, mCount;

  logic [3:0]  seenReady, seenRespValid;
  logic [31:0] seenRespData;

  waverforms_mul_arbiter #(.NUM_REQ(N)) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cycleNo);
    end
  endtask

  function automatic bit bitSet(input logic [3:0] v, input int i);
    return ((v >> i) & 4'b0001) != 4'b0000;
  endfunction

  function automatic int pickGrant(input logic [3:0] v, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (bitSet(v, (ptr + i) % N)) return (ptr + i) % N;
    end
    return -1;
  endfunction

  function automatic int oneHotIdx(input logic [3:0] v);
    for (int i = 0; i < N; i++) begin
      if (bitSet(v, i)) return i;
    end
    return -1;
  endfunction

  // Mathematical product of signed a and unsigned b, reduced modulo 2^32.
  function automatic logic [31:0] refProduct(input logic [31:0] a, input logic [31:0] b);
    longint sa, ub, p;
    sa = longint'($signed(a));
    ub = longint'({32'b0, b});
    p  = sa * ub;
    return p[31:0];
  endfunction

  task automatic modelReset();
    mPhase = 0; mPtr = 0; mGnt = 0; mRes = '0; mCount = '0; mA = '0; mB = '0;
  endtask

  // Drive one cycle of inputs, compare at the falling edge, advance the model.
  task automatic applyStimulus(input logic rst, input logic [3:0] valid,
                               input logic [N*32-1:0] a, input logic [N*32-1:0] b,
                               input logic [3:0] rready);
    int         g;
    logic [3:0] expReady, expRespValid;
    ap_rst = rst; req_valid = valid; req_a = a; req_b = b; resp_ready = rready;
    @(negedge ap_clk);
    g            = (mPhase == 0) ? pickGrant(valid, mPtr) : -1;
    expReady     = (g >= 0 && !rst) ? 4'(1 << g) : 4'b0000;
    expRespValid = (mPhase == 2 && !rst) ? 4'(1 << mGnt) : 4'b0000;
    checkOutput("reqReady", 32'(req_ready), 32'(expReady));
    checkOutput("respValid", 32'(resp_valid), 32'(expRespValid));
    checkOutput("busy", 32'(busy), (mPhase != 0) ? 32'd1 : 32'd0);
    checkOutput("opCount", op_count, mCount);
    if (expRespValid != 4'b0000) checkOutput("respData", resp_data, mRes);
    seenReady     = req_ready;
    seenRespValid = resp_valid;
    seenRespData  = resp_data;
    if (rst) begin
      modelReset();
    end else begin
      case (mPhase)
        0: if (g >= 0) begin
          mA = a[32*g +: 32];
          mB = b[32*g +: 32];
          mGnt = g;
          mPtr = (g + 1) % N;
          mPhase = 1;
        end
        1: begin
          mRes = refProduct(mA, mB);
          mPhase = 2;
        end
        default: if (bitSet(rready, mGnt)) begin
          mCount = mCount + 32'd1;
          mPhase = 0;
        end
      endcase
    end
    @(posedge ap_clk);
    #1;
    cycleNo++;
  endtask

  // One complete operation from a single requester with resp_ready high.
  task automatic runOne(input int id, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] data, output logic [3:0] rv);
    logic [N*32-1:0] va, vb;
    va = '0; vb = '0;
    va[32*id +: 32] = a;
    vb[32*id +: 32] = b;
    applyStimulus(1'b0, 4'(1 << id), va, vb, 4'hF);
    applyStimulus(1'b0, 4'h0, va, vb, 4'hF);
    applyStimulus(1'b0, 4'h0, va, vb, 4'hF);
    data = seenRespData;
    rv   = seenRespValid;
  endtask

  initial begin
    logic [31:0]     d;
    logic [3:0]      rv, rr;
    logic [N*32-1:0] fa, fb, ra, rb;
    int              gIdx[$];
    int              gCyc[$];
    logic            rst;

    ap_rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = '0;
    seenReady = '0; seenRespValid = '0; seenRespData = '0;
    modelReset();
    @(posedge ap_clk);
    #1;
    applyStimulus(1'b1, 4'h0, '0, '0, 4'h0);
    checkOutput("rstRespData", resp_data, 32'h0);
    checkOutput("rstBusy", 32'(busy), 32'd0);

    // Signed x unsigned and width edge cases
    runOne(0, 32'hFFFF_FFFD, 32'd5, d, rv);
    checkOutput("negMulData", d, 32'hFFFF_FFF1);
    checkOutput("negMulValid", 32'(rv), 32'h1);
    checkOutput("negMulCount", op_count, 32'd1);
    runOne(1, 32'h7FFF_FFFF, 32'd2, d, rv);
    checkOutput("maxPosData", d, 32'hFFFF_FFFE);
    runOne(2, 32'hFFFF_FFFF, 32'h8000_0000, d, rv);
    checkOutput("unsignedBData", d, 32'h8000_0000);
    checkOutput("threeOpsCount", op_count, 32'd3);

    // Reset clears result and counter
    applyStimulus(1'b1, 4'h0, '0, '0, 4'h0);
    checkOutput("rstRespData2", resp_data, 32'h0);
    checkOutput("rstCount", op_count, 32'd0);

    // Fairness: everyone valid, responses always accepted
    for (int i = 0; i < N; i++) begin
      fa[32*i +: 32] = 32'(i + 3);
      fb[32*i +: 32] = 32'(i + 7);
    end
    for (int k = 0; k < 15; k++) begin
      applyStimulus(1'b0, 4'hF, fa, fb, 4'hF);
      if (seenReady != 4'h0) begin
        gIdx.push_back(oneHotIdx(seenReady));
        gCyc.push_back(k);
      end
    end
    checkOutput("fairNumGrants", 32'(gIdx.size()), 32'd5);
    for (int k = 0; k < gIdx.size(); k++) begin
      checkOutput("fairOrder", 32'(gIdx[k]), 32'(k % N));
      if (k > 0) checkOutput("fairSpacing", 32'(gCyc[k] - gCyc[k-1]), 32'd3);
    end
    checkOutput("fairCount", op_count, 32'd5);

    // Backpressure on requester 2 while requester 1 waits
    fa = '0; fb = '0;
    fa[64 +: 32] = 32'h1234_5678; fb[64 +: 32] = 32'h0000_0010;
    fa[32 +: 32] = 32'h0000_0009; fb[32 +: 32] = 32'h0000_0003;
    applyStimulus(1'b0, 4'b0100, fa, fb, 4'b1011);
    applyStimulus(1'b0, 4'b0010, fa, fb, 4'b1011);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 4'b0010, fa, fb, 4'b1011);
      checkOutput("bpData", seenRespData, 32'h2345_6780);
      checkOutput("bpReady", 32'(seenReady), 32'h0);
    end
    applyStimulus(1'b0, 4'b0010, fa, fb, 4'b0100);
    applyStimulus(1'b0, 4'b0010, fa, fb, 4'b0000);
    checkOutput("bpNextGrant", 32'(seenReady), 32'b0010);
    applyStimulus(1'b0, 4'b0000, fa, fb, 4'hF);
    applyStimulus(1'b0, 4'b0000, fa, fb, 4'hF);
    checkOutput("bpCount", op_count, 32'd7);

    // Reset while in MUL discards the operation
    applyStimulus(1'b0, 4'b1000, fa, fb, 4'hF);
    applyStimulus(1'b1, 4'b0000, fa, fb, 4'hF);
    checkOutput("rstMidBusy", 32'(busy), 32'd0);
    checkOutput("rstMidRespValid", 32'(resp_valid), 32'h0);
    checkOutput("rstMidCount", op_count, 32'd0);
    applyStimulus(1'b0, 4'hF, fa, fb, 4'hF);
    checkOutput("rstMidPtr", 32'(seenReady), 32'b0001);
    applyStimulus(1'b0, 4'h0, fa, fb, 4'hF);
    applyStimulus(1'b0, 4'h0, fa, fb, 4'hF);

    // Foreign resp_ready bits are ignored
    applyStimulus(1'b0, 4'b1000, fa, fb, 4'h0);
    applyStimulus(1'b0, 4'b0000, fa, fb, 4'h0);
    applyStimulus(1'b0, 4'b0000, fa, fb, 4'b0010);
    applyStimulus(1'b0, 4'b0000, fa, fb, 4'b0010);
    checkOutput("foreignHold", 32'(seenRespValid), 32'b1000);
    applyStimulus(1'b0, 4'b0000, fa, fb, 4'b1000);
    checkOutput("foreignBusy", 32'(busy), 32'd0);
    checkOutput("foreignCount", op_count, 32'd2);

    // Randomized traffic; pending requests usually hold operands stable
    rv = '0; ra = '0; rb = '0;
    for (int c = 0; c < 500; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < N; i++) begin
        if (!(bitSet(rv, i) && !bitSet(seenReady, i) && $urandom_range(0, 7) != 0)) begin
          if ($urandom_range(0, 1) == 1) rv = rv | 4'(1 << i);
          else                           rv = rv & ~4'(1 << i);
          ra[32*i +: 32] = $urandom();
          rb[32*i +: 32] = $urandom();
        end
      end
      rr = 4'($urandom_range(0, 15));
      applyStimulus(rst, rv, ra, rb, rr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/waverforms_mul_arbiter.md
# waverforms_mul_arbiter

Round-robin arbiter and sequencer that shares one 32s×32ns→32 combinational multiplier core among `NUM_REQ` waveform channels, e.g. amplitude scaling and phase-increment products. Each channel issues a valid/ready operand request and receives a held response. The block sits between the per-voice waveform generators and the single multiplier instance, so only one multiplier is spent on DSP resources.

## Interface
- `NUM_REQ`, 4: number of requesters, range 2..16.
- `ID_W`, `$clog2(NUM_REQ)`: grant index width (derived; do not override).

Ports:
- `ap_clk`  in  1  sole clock; all logic on the rising edge.
- `ap_rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  `NUM_REQ`  per-requester operand valid.
- `req_ready`  out  `NUM_REQ`  one-hot accept, asserted only in the grant cycle.
- `req_a`  in  `NUM_REQ*32`  packed signed operand A; slice i is `[32*i+31:32*i]`.
- `req_b`  in  `NUM_REQ*32`  packed unsigned operand B, same packing as `req_a`.
- `resp_valid`  out  `NUM_REQ`  one-hot result valid, held until accepted.
- `resp_ready`  in  `NUM_REQ`  per-requester result accept.
- `resp_data`  out  32  product low 32 bits; meaningful only while `resp_valid` is non-zero.
- `busy`  out  1  high whenever the state is not IDLE.
- `op_count`  out  32  completed-operation counter; wraps modulo 2^32.

## Operation
- FSM with three states: IDLE, MUL, RESP.
- IDLE:
  - If `req_valid` is non-zero, grant the first set bit searching upward from `rr_ptr`, wrapping modulo `NUM_REQ`.
  - In the same cycle, assert `req_ready[g]` combinationally and register `req_a[g]`, `req_b[g]` and `g` into `op_a`, `op_b`, `gnt_id`.
  - Set `rr_ptr` to `(g+1) mod NUM_REQ`, then go to MUL.
  - If `req_valid` is zero, stay in IDLE.
- MUL:
  - Feed `op_a`/`op_b` to the multiplier.
  - Register `res <= low32($signed(op_a) * $signed({1'b0, op_b}))`, i.e. two's-complement wrap with no saturation.
  - Go to RESP.
- RESP:
  - Drive `resp_valid[gnt_id]=1` and `resp_data=res`.
  - When `resp_ready[gnt_id]` is seen: increment `op_count` and go to IDLE.
  - `resp_ready` bits of non-granted requesters are ignored.
- `req_ready` is zero outside the IDLE grant cycle. A requester must hold `req_a`/`req_b` stable while `req_valid` is high and not yet accepted.
- A requester dropping `req_valid` before it is granted is legal; its request is simply not served.
- A single-bit `req_valid` always wins, regardless of `rr_ptr`.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `gnt_id`=0, `res`=0, `op_count`=0.
- Outputs during and immediately after reset: `req_ready`=0, `resp_valid`=0, `busy`=0, `resp_data`=0.
- Reset dominates every other condition in the same cycle. Asserting reset in MUL or RESP discards the operation with no response and no count increment.
- Latency from grant edge (G) to `resp_valid` high: 2 cycles (G → MUL → RESP).
- Minimum issue interval is 3 cycles, when `resp_ready` is already high on entry to RESP.
- `resp_ready` low stalls the block indefinitely in RESP. `resp_data` stays stable and no new grant occurs.
- Response to grant is combinational within one cycle: `req_ready` depends on `req_valid` and `rr_ptr` only.
- Round-robin guarantees that any continuously asserted request is granted within `NUM_REQ` grants.
- If `op_count` is at 0xFFFFFFFF when a response is accepted, it becomes 0.

## Structure
- Shared package `waverforms_pkg`:
  - `MUL_W`=32 constant.
  - State enum `mul_arb_state_t` {IDLE, MUL, RESP}.
  - Function returning the first set bit of a vector searched from a rotating start index.
- One sub-module: `waverforms_mul_32s_32ns_32_1_1`, the existing combinational multiplier core.
  - Instantiated once with `din0_WIDTH`=32, `din1_WIDTH`=32, `dout_WIDTH`=32.
  - Its output is registered into `res` in MUL.
- Arbiter priority logic and FSM stay inline; no other sub-modules.

## Test plan
- Signed × unsigned: requester 0 issues a=0xFFFFFFFD (−3), b=5 → `resp_valid[0]` 2 cycles after grant, `resp_data`=0xFFFFFFF1, `op_count`=1.
- Width edge cases:
  - a=0x7FFFFFFF, b=2 → 0xFFFFFFFE.
  - a=0xFFFFFFFF, b=0x80000000 → 0x80000000, with b treated as unsigned 2^31.
- Fairness: all 4 requesters held valid from reset with `resp_ready` tied high → grants 0,1,2,3,0 in order, a grant every 3 cycles, `op_count`=5 after the fifth response.
- Backpressure: hold `resp_ready[2]` low for 10 cycles in RESP while requester 1 stays valid → `resp_data` stable, `req_ready`=0 throughout; requester 1 is granted the cycle after `resp_ready[2]` is accepted.
- Reset mid-operation: assert `ap_rst` in MUL → next cycle shows IDLE, `resp_valid`=0, `op_count` unchanged at 0, `rr_ptr`=0 (a subsequent all-valid request grants requester 0).
- Ignore foreign ready: in RESP for `gnt_id`=3, pulse `resp_ready[1]` → no state change; then `resp_ready[3]` → IDLE and `op_count` increments.
